calc_req_driver: RTL and testbench
==================================

# calc_req_driver

Initiator-side port driver for the CALC1 calculator. It accepts one complete operation (command plus two operands) from a host-side handshake and serialises it onto one calculator request port using the two-cycle command/operand protocol. It then waits for that port's response (`out_resp`/`out_data`), holds the result until the host accepts it, and optionally aborts on a response timeout. One instance sits on each of the four calculator request ports.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles before abort (used only with `CALC_REQ_TIMEOUT_EN`); legal range 2..255.
- `c_clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host offers an operation.
- `cmd_ready`  out  1  driver can accept an operation.
- `cmd_op`  in  [0:3]  command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr.
- `cmd_op1`  in  [0:31]  operand 1.
- `cmd_op2`  in  [0:31]  operand 2.
- `req_cmd_out`  out  [0:3]  command to the calculator port.
- `req_data_out`  out  [0:31]  operand to the calculator port.
- `out_resp`  in  [0:1]  calculator response: 00 none, 01 ok, 10 overflow/underflow, 11 invalid.
- `out_data`  in  [0:31]  calculator result.
- `rsp_valid`  out  1  result held for the host.
- `rsp_ready`  in  1  host accepts the result.
- `rsp_resp`  out  [0:1]  captured response code.
- `rsp_data`  out  [0:31]  captured result.
- `proto_err`  out  1  sticky: a non-zero `out_resp` arrived outside WAIT.
- `timeout`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, SEND1, SEND2, WAIT, DONE.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch op/op1/op2.
  - If op≠0, go to SEND1.
  - If op=0, go to DONE with `rsp_resp`=00 and `rsp_data`=0. Nothing is driven on the port.
- SEND1: `req_cmd_out`=op, `req_data_out`=op1. Go to SEND2.
- SEND2: `req_cmd_out`=0, `req_data_out`=op2. Go to WAIT.
- WAIT
  - `req_cmd_out`=0, `req_data_out`=0.
  - When `out_resp`≠00, capture `out_resp`/`out_data` into `rsp_resp`/`rsp_data` and go to DONE.
- DONE
  - `rsp_valid`=1; the port is driven to zero.
  - On `rsp_ready`, go to IDLE.
- Any non-zero `out_resp` seen in IDLE, SEND1, SEND2 or DONE is ignored for data purposes and sets `proto_err`. Only reset clears `proto_err`.
- Commands other than 0 (including invalid codes 3, 4, 7..15) are forwarded unchanged. The calculator's 11 response is passed through.
- Operands and result pass through unmodified; there is no arithmetic in this block.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1 (after reset deasserts).
  - `req_cmd_out`=0, `req_data_out`=0.
  - `rsp_valid`=0, `rsp_resp`=00, `rsp_data`=0.
  - `proto_err`=0, `timeout`=0, timeout counter=0.
- Reset is asserted asynchronously. Any in-flight operation is dropped with no response.
- All port and host outputs are registered.
- Accept at edge N:
  - cmd/op1 on the port during cycle N+1.
  - op2 during cycle N+2.
  - WAIT from N+3.
- A response sampled at edge M in WAIT gives `rsp_valid`=1 from cycle M+1.
- `cmd_ready` is 0 from the cycle after accept until the cycle after the `rsp_ready` handshake.
  - Minimum turnaround is one IDLE cycle between operations.
  - No back-to-back accept in DONE.
- `rsp_ready` held high while `rsp_valid` rises completes the handshake on the first DONE edge. `rsp_valid` is then high for exactly one cycle.
- `cmd_valid` is ignored outside IDLE. The host must hold cmd fields stable only at the accepting edge.

## Configuration
- `CALC_REQ_TIMEOUT_EN` defined:
  - A counter starts at 0 on entering WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` with no response:
    - go to DONE with `rsp_resp`=00, `rsp_data`=0;
    - pulse `timeout` for one cycle (the first DONE cycle).
  - A response arriving on the same edge the count reaches `TIMEOUT` wins; no timeout pulse.
- `CALC_REQ_TIMEOUT_EN` undefined:
  - No counter; WAIT persists indefinitely.
  - `timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Add: op=1, op1=4096, op2=1234, calculator returns 01/5330 three cycles after SEND2. Required:
  - port shows 1/4096 then 0/1234;
  - `rsp_valid` with 01/5330;
  - `cmd_ready` returns after `rsp_ready`.
- Overflow: op=1, op1=0xFFFFFFFF, op2=1, calculator returns 10/0. Required: `rsp_resp`=10, `rsp_data`=0.
- No-op: op=0. Required:
  - `req_cmd_out` stays 0;
  - `rsp_valid` one cycle after accept with 00/0.
- Stray response: `out_resp`=01 during SEND1. Required:
  - `proto_err`=1 sticky;
  - the later WAIT response 01/7 is still captured.
- Timeout (macro on, `TIMEOUT`=8): no response. Required:
  - `timeout` pulse;
  - `rsp_resp`=00 exactly 8 WAIT cycles after entering WAIT.
  - With the macro off, `rsp_valid` stays 0 for 1000 cycles.
- Reset mid-WAIT: drop `reset_n` asynchronously. Required:
  - all outputs return to reset values immediately;
  - the next op=2, op1=10, op2=3 with a calculator return of 01/7 completes normally.

Source files
------------

// File: rtl/calc_req_driver_if.sv
// Host handshake, calculator request port and status signals for one calc_req_driver.
// The driver takes the master modport; the host/calculator side takes the slave modport.
interface calc_req_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [0:3]  cmd_op;
  logic [0:31] cmd_op1;
  logic [0:31] cmd_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic        proto_err;
  logic        timeout;

  modport master (
    input  cmd_valid, cmd_op, cmd_op1, cmd_op2, out_resp, out_data, rsp_ready,
    output cmd_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           proto_err, timeout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_op1, cmd_op2, out_resp, out_data, rsp_ready,
    input  cmd_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data,
           proto_err, timeout
  );
endinterface

// File: rtl/calc_req_driver.sv
// CALC1 request-port driver: serialises one host operation onto the port and holds the result.
// Optional WAIT timeout abort is built when CALC_REQ_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a host operation
// SEND1 | port carries command and operand 1
// SEND2 | port carries command 0 and operand 2
// WAIT  | port idle, waiting for a non-zero out_resp
// DONE  | result held with rsp_valid until rsp_ready
module calc_req_driver #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic c_clk,
  input  logic reset_n,
  calc_req_driver_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_DONE
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("calc_req_driver: TIMEOUT must be within 2..255");
  end

  state_t      state, state_nxt;
  logic [0:31] op2_q, op2_nxt;
  logic [0:3]  req_cmd_q, req_cmd_nxt;
  logic [0:31] req_data_q, req_data_nxt;
  logic        cmd_ready_q, cmd_ready_nxt;
  logic        rsp_valid_q, rsp_valid_nxt;
  logic [0:1]  rsp_resp_q, rsp_resp_nxt;
  logic [0:31] rsp_data_q, rsp_data_nxt;
  logic        proto_err_q, proto_err_nxt;
  logic        resp_seen;

`ifdef CALC_REQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);
  logic [7:0] wait_cnt_q, wait_cnt_nxt, wait_cnt_inc;
  logic       timeout_q, timeout_nxt;
`endif

  assign resp_seen = (bus.out_resp != 2'b00);

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op2_q       <= '0;
      req_cmd_q   <= '0;
      req_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_data_q  <= '0;
      proto_err_q <= 1'b0;
`ifdef CALC_REQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      op2_q       <= op2_nxt;
      req_cmd_q   <= req_cmd_nxt;
      req_data_q  <= req_data_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_resp_q  <= rsp_resp_nxt;
      rsp_data_q  <= rsp_data_nxt;
      proto_err_q <= proto_err_nxt;
`ifdef CALC_REQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_nxt;
      timeout_q   <= timeout_nxt;
`endif
    end
  end

`ifdef CALC_REQ_TIMEOUT_EN
  assign wait_cnt_inc = wait_cnt_q + 8'd1;
`endif

  // Port and host outputs are registered, so every output value is computed
  // here from the state being entered rather than the current one.
  always_comb begin
    state_nxt     = state;
    op2_nxt       = op2_q;
    req_cmd_nxt   = '0;
    req_data_nxt  = '0;
    rsp_resp_nxt  = rsp_resp_q;
    rsp_data_nxt  = rsp_data_q;
    proto_err_nxt = proto_err_q | ((state != ST_WAIT) && resp_seen);
`ifdef CALC_REQ_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt_q;
    timeout_nxt   = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op2_nxt = bus.cmd_op2;
          if (bus.cmd_op != 4'd0) begin
            state_nxt    = ST_SEND1;
            req_cmd_nxt  = bus.cmd_op;
            req_data_nxt = bus.cmd_op1;
          end else begin
            state_nxt    = ST_DONE;
            rsp_resp_nxt = 2'b00;
            rsp_data_nxt = '0;
          end
        end
      end

      ST_SEND1: begin
        state_nxt    = ST_SEND2;
        req_data_nxt = op2_q;
      end

      ST_SEND2: begin
        state_nxt = ST_WAIT;
`ifdef CALC_REQ_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end

      ST_WAIT: begin
        // A response on the terminal-count edge takes priority over the abort.
        if (resp_seen) begin
          state_nxt    = ST_DONE;
          rsp_resp_nxt = bus.out_resp;
          rsp_data_nxt = bus.out_data;
        end
`ifdef CALC_REQ_TIMEOUT_EN
        else if (wait_cnt_inc == TIMEOUT_TC) begin
          state_nxt    = ST_DONE;
          rsp_resp_nxt = 2'b00;
          rsp_data_nxt = '0;
          timeout_nxt  = 1'b1;
          wait_cnt_nxt = wait_cnt_inc;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
        end
`endif
      end

      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    rsp_valid_nxt = (state_nxt == ST_DONE);
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.req_cmd_out  = req_cmd_q;
  assign bus.req_data_out = req_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_resp     = rsp_resp_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.proto_err    = proto_err_q;

`ifdef CALC_REQ_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_req_driver.sv
// Self-checking bench for calc_req_driver: directed scenarios plus randomized operations
// checked against a transaction-level expectation of the port sequence and result timing.
module tb_calc_req_driver;

  logic c_clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  bit   pe_exp;

  calc_req_driver_if bus ();

  calc_req_driver #(.TIMEOUT(8)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // One complete operation: accept, port sequence, response after lat WAIT cycles,
  // rsp_ready after rdly extra DONE cycles. Optional stray response during SEND1.
  task automatic run_op(input logic [0:3] op, input logic [0:31] op1, input logic [0:31] op2,
                        input logic [0:1] resp, input logic [0:31] data,
                        input int lat, input int rdly, input bit stray, input string tag);
    logic [0:1]  exp_resp;
    logic [0:31] exp_data;
    int guard;
    exp_resp = (op == 4'd0) ? 2'b00 : resp;
    exp_data = (op == 4'd0) ? 32'd0 : data;

    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ready_wait: cmd_ready=%b want 1", tag, bus.cmd_ready);
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_op1   = op1;
    bus.cmd_op2   = op2;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_op1   = $urandom;
    bus.cmd_op2   = $urandom;

    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL %s busy: cmd_ready=%b want 0", tag, bus.cmd_ready);
    end

    if (op != 4'd0) begin
      n_cmp++;
      if (bus.req_cmd_out !== op || bus.req_data_out !== op1) begin
        n_err++; $display("FAIL %s send1: port=%0d/%h want %0d/%h", tag,
                          bus.req_cmd_out, bus.req_data_out, op, op1);
      end
      if (stray) begin
        bus.out_resp = 2'b01;
        bus.out_data = 32'hDEAD_BEEF;
        pe_exp = 1'b1;
      end
      step();
      bus.out_resp = 2'b00;
      bus.out_data = $urandom;
      n_cmp++;
      if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== op2) begin
        n_err++; $display("FAIL %s send2: port=%0d/%h want 0/%h", tag,
                          bus.req_cmd_out, bus.req_data_out, op2);
      end
      step();
      n_cmp++;
      if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL %s wait_port: port=%0d/%h rsp_valid=%b want 0/0/0", tag,
                          bus.req_cmd_out, bus.req_data_out, bus.rsp_valid);
      end
      for (int i = 0; i < lat; i++) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_cmd_out !== 4'd0) begin
          n_err++; $display("FAIL %s wait_idle[%0d]: rsp_valid=%b cmd=%0d want 0/0", tag, i,
                            bus.rsp_valid, bus.req_cmd_out);
        end
        step();
      end
      bus.cmd_valid = 1'b0;
      bus.out_resp  = resp;
      bus.out_data  = data;
      step();
      bus.out_resp  = 2'b00;
      bus.out_data  = $urandom;
    end

    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== exp_resp || bus.rsp_data !== exp_data) begin
      n_err++; $display("FAIL %s result: valid/resp/data=%b/%b/%h want 1/%b/%h", tag,
                        bus.rsp_valid, bus.rsp_resp, bus.rsp_data, exp_resp, exp_data);
    end
    n_cmp++;
    if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.cmd_ready !== 1'b0 ||
        bus.timeout !== 1'b0 || bus.proto_err !== pe_exp) begin
      n_err++; $display("FAIL %s done_status: cmd/data/ready/tmo/perr=%0d/%h/%b/%b/%b want 0/0/0/0/%b",
                        tag, bus.req_cmd_out, bus.req_data_out, bus.cmd_ready, bus.timeout,
                        bus.proto_err, pe_exp);
    end

    for (int i = 0; i < rdly; i++) begin
      step();
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL %s hold[%0d]: valid/data/ready=%b/%h/%b want 1/%h/0", tag, i,
                          bus.rsp_valid, bus.rsp_data, bus.cmd_ready, exp_data);
      end
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s release: rsp_valid=%b cmd_ready=%b want 0/1", tag,
                        bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_op1   = '0;
    bus.cmd_op2   = '0;
    bus.out_resp  = '0;
    bus.out_data  = '0;
    bus.rsp_ready = 1'b0;
    pe_exp        = 1'b0;
    #12;
    n_cmp++;
    if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_resp !== 2'b00 || bus.rsp_data !== 32'd0 || bus.proto_err !== 1'b0 ||
        bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_values: cmd/data/valid/resp/rdata/perr/tmo=%0d/%h/%b/%b/%h/%b/%b want all 0",
                        bus.req_cmd_out, bus.req_data_out, bus.rsp_valid, bus.rsp_resp,
                        bus.rsp_data, bus.proto_err, bus.timeout);
    end
    #10;
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: cmd_ready=%b rsp_valid=%b want 1/0",
                        bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_add();
    run_op(4'd1, 32'd4096, 32'd1234, 2'b01, 32'd5330, 2, 1, 1'b0, "add");
  endtask

  task automatic test_overflow();
    run_op(4'd1, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd0, 0, 0, 1'b0, "overflow");
  endtask

  task automatic test_noop();
    run_op(4'd0, $urandom, $urandom, 2'b01, 32'd123, 0, 2, 1'b0, "noop");
  endtask

  task automatic test_stray();
    run_op(4'd1, 32'd3, 32'd4, 2'b01, 32'd7, 1, 0, 1'b1, "stray");
    step();
    n_cmp++;
    if (bus.proto_err !== 1'b1) begin
      n_err++; $display("FAIL stray_sticky: proto_err=%b want 1", bus.proto_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:3]  op;
    logic [0:1]  resp;
    for (int n = 0; n < 24; n++) begin
      op   = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(1, 3));
      run_op(op, $urandom, $urandom, resp, $urandom, $urandom_range(0, 5),
             $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  task automatic test_timeout();
`ifdef CALC_REQ_TIMEOUT_EN
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd5;
    bus.cmd_op1   = 32'h1111_0000;
    bus.cmd_op2   = 32'd2;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.timeout !== 1'b0) begin
        n_err++; $display("FAIL tmo_wait[%0d]: rsp_valid=%b timeout=%b want 0/0", i,
                          bus.rsp_valid, bus.timeout);
      end
      step();
    end
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.timeout !== 1'b1 || bus.rsp_resp !== 2'b00 ||
        bus.rsp_data !== 32'd0) begin
      n_err++; $display("FAIL tmo_abort: valid/tmo/resp/data=%b/%b/%b/%h want 1/1/00/0",
                        bus.rsp_valid, bus.timeout, bus.rsp_resp, bus.rsp_data);
    end
    step();
    n_cmp++;
    if (bus.timeout !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL tmo_pulse: timeout=%b rsp_valid=%b want 0/1", bus.timeout, bus.rsp_valid);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    run_op(4'd2, 32'd50, 32'd8, 2'b01, 32'd42, 7, 0, 1'b0, "tmo_edge_resp");
    run_op(4'd6, 32'd64, 32'd1, 2'b11, 32'd9, 6, 1, 1'b0, "tmo_near");
`else
    int seen;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd5;
    bus.cmd_op1   = 32'h1111_0000;
    bus.cmd_op2   = 32'd2;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.timeout !== 1'b0) seen++;
      step();
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL no_timeout: %0d cycles with rsp_valid/timeout set, want 0", seen);
    end
    bus.out_resp = 2'b01;
    bus.out_data = 32'h0000_0100;
    step();
    bus.out_resp = 2'b00;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b01 || bus.rsp_data !== 32'h0000_0100) begin
      n_err++; $display("FAIL late_resp: valid/resp/data=%b/%b/%h want 1/01/00000100",
                        bus.rsp_valid, bus.rsp_resp, bus.rsp_data);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_wait();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd1;
    bus.cmd_op1   = 32'd77;
    bus.cmd_op2   = 32'd88;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    step();
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_cmd_out !== 4'd0 || bus.req_data_out !== 32'd0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_resp !== 2'b00 || bus.rsp_data !== 32'd0 || bus.proto_err !== 1'b0 ||
        bus.timeout !== 1'b0) begin
      n_err++; $display("FAIL async_reset: cmd/data/valid/resp/rdata/perr/tmo=%0d/%h/%b/%b/%h/%b/%b want all 0",
                        bus.req_cmd_out, bus.req_data_out, bus.rsp_valid, bus.rsp_resp,
                        bus.rsp_data, bus.proto_err, bus.timeout);
    end
    pe_exp = 1'b0;
    #7;
    reset_n = 1'b1;
    step();
    run_op(4'd2, 32'd10, 32'd3, 2'b01, 32'd7, 1, 0, 1'b0, "post_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_overflow();
    test_noop();
    test_stray();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
